// File: rtl/axi_slave_write_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_slave_write_mem : single-outstanding AXI write slave over 64-bit memory
// Revision 1.0
// ---------------------------------------------------------------------------
module axi_slave_write_mem #(
  parameter int addr_width = 32,
  parameter int data_width = 64,
  parameter int mem_depth  = 256
) (
  input  logic                         AClk,
  input  logic                         ARstn,
  input  logic [7:0]                   AWID,
  input  logic [addr_width-1:0]        AWADDR,
  input  logic [7:0]                   AWLEN,
  input  logic [2:0]                   AWSIZE,
  input  logic [1:0]                   AWBURST,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [3:0]                   WID,
  input  logic [data_width-1:0]        WDATA,
  input  logic [data_width/8-1:0]      WSTRB,
  input  logic                         WLAST,
  input  logic                         WVALID,
  output logic                         WREADY,
  output logic [3:0]                   BID,
  output logic [1:0]                   BRESP,
  output logic                         BVALID,
  input  logic                         BREADY,
  input  logic [$clog2(mem_depth)-1:0] dbg_addr,
  output logic [data_width-1:0]        dbg_rdata,
  output logic [15:0]                  burst_cnt
);

  localparam int IDX_W = $clog2(mem_depth);
  localparam int LANES = data_width / 8;
  localparam logic [addr_width:0] MEM_BYTES = (addr_width + 1)'(mem_depth) << 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            id_q, id_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [15:0]           bcnt_q, bcnt_d;

  logic [data_width-1:0] mem [mem_depth];

  logic                  burst_bad;
  logic                  last_beat;
  logic                  beat_ok;
  logic                  mem_we;
  logic [addr_width-1:0] beat_addr;
  logic [IDX_W-1:0]      widx;
  logic                  unused_ok;

  // Only 8-byte INCR/FIXED bursts are serviced; anything else is answered with SLVERR.
  assign burst_bad = (size_q != 3'd3) || burst_q[1];
  assign last_beat = (cnt_q == len_q);
  assign beat_addr = (burst_q == 2'b00) ? addr_q : addr_q + (addr_width'(cnt_q) << 3);
  assign beat_ok   = ({1'b0, beat_addr} < MEM_BYTES);
  assign widx      = beat_addr[IDX_W+2:3];
  assign mem_we    = (state_q == S_DATA) && WVALID && !burst_bad && beat_ok;
  assign unused_ok = ^WID;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      S_IDLE: begin
        if (AWVALID) begin
          id_d    = AWID[3:0];
          addr_d  = AWADDR;
          len_d   = AWLEN;
          size_d  = AWSIZE;
          burst_d = AWBURST;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (WVALID) begin
          // The beat count alone ends the burst; a wrong WLAST only flags an error.
          if (burst_bad || !beat_ok || (WLAST != last_beat)) err_d = 1'b1;
          if (last_beat) state_d = S_RESP;
          else           cnt_d   = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        if (BREADY) begin
          state_d = S_IDLE;
          bcnt_d  = bcnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge AClk or negedge ARstn) begin
    if (!ARstn) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive ARstn.
  always_ff @(posedge AClk) begin
    if (mem_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (WSTRB[i]) mem[widx][8*i +: 8] <= WDATA[8*i +: 8];
      end
    end
  end

  assign AWREADY   = (state_q == S_IDLE);
  assign WREADY    = (state_q == S_DATA);
  assign BVALID    = (state_q == S_RESP);
  assign BID       = id_q;
  assign BRESP     = err_q ? 2'b10 : 2'b00;
  assign burst_cnt = bcnt_q;
  assign dbg_rdata = mem[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_write_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axi_slave_write_mem : directed + random bursts against a byte-level model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_axi_slave_write_mem;

  localparam int DEPTH = 256;

  logic        AClk = 1'b0;
  logic        ARstn;
  logic [7:0]  AWID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [3:0]  WID;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [7:0]  dbg_addr;
  logic [63:0] dbg_rdata;
  logic [15:0] burst_cnt;

  axi_slave_write_mem #(.addr_width(32), .data_width(64), .mem_depth(DEPTH)) dut (
    .AClk(AClk), .ARstn(ARstn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .burst_cnt(burst_cnt)
  );

  always #5 AClk = ~AClk;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] model_mem [DEPTH];
  int          model_bcnt = 0;
  logic [63:0] q_data [$];
  logic [7:0]  q_strb [$];
  int          force_last = -1;
  bit          gap_alt = 1'b0;
  bit          gap_rand = 1'b0;
  bit          simul = 1'b0;
  int          bready_delay = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge AClk);
    #1;
  endtask

  task automatic load(input int n, input bit rand_strb);
    q_data.delete();
    q_strb.delete();
    for (int k = 0; k < n; k++) begin
      q_data.push_back({$urandom, $urandom});
      q_strb.push_back(rand_strb ? 8'($urandom) : 8'hFF);
    end
  endtask

  // Reference: walk the beats, update a byte-accurate image, decide OKAY/SLVERR.
  task automatic model_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] bt, output logic [1:0] resp);
    bit          bad;
    bit          err;
    logic [31:0] a;
    bad = (size != 3'd3) || (bt == 2'b10) || (bt == 2'b11);
    err = bad;
    for (int k = 0; k <= int'(len); k++) begin
      a = (bt == 2'b00) ? addr : addr + 32'(8 * k);
      if (k == force_last) err = 1'b1;
      if (a >= 32'(DEPTH * 8)) err = 1'b1;
      else if (!bad) begin
        for (int i = 0; i < 8; i++)
          if (q_strb[k][i]) model_mem[a[10:3]][8*i +: 8] = q_data[k][8*i +: 8];
      end
    end
    resp = err ? 2'b10 : 2'b00;
  endtask

  task automatic drive_beat(input int b, input logic [7:0] len);
    WVALID = 1'b1;
    WDATA  = q_data[b];
    WSTRB  = q_strb[b];
    WLAST  = (b == int'(len)) ^ (b == force_last);
  endtask

  task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] bt, input string tag);
    logic [1:0] exp_resp;
    int         b;
    int         cyc;
    bit         wr_ok;
    model_burst(addr, len, size, bt, exp_resp);
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = bt; AWVALID = 1'b1;
    if (simul) drive_beat(0, len);
    check({tag, ".awready"}, 64'(AWREADY), 64'd1);
    tick();
    AWVALID = 1'b0;
    check({tag, ".wready_entry"}, 64'(WREADY), 64'd1);
    check({tag, ".awready_data"}, 64'(AWREADY), 64'd0);
    b = 0; cyc = 0; wr_ok = 1'b1;
    while (b <= int'(len) && cyc < 2000) begin
      if ((gap_alt && cyc[0]) || (gap_rand && $urandom_range(0, 3) == 0)) WVALID = 1'b0;
      else drive_beat(b, len);
      if (WREADY !== 1'b1) wr_ok = 1'b0;
      tick();
      if (WVALID) b++;
      cyc++;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    check({tag, ".beats"}, 64'(b), 64'(len) + 64'd1);
    check({tag, ".wready_held"}, 64'(wr_ok), 64'd1);
    check({tag, ".bvalid"}, 64'(BVALID), 64'd1);
    check({tag, ".bid"}, 64'(BID), 64'(id[3:0]));
    check({tag, ".bresp"}, 64'(BRESP), 64'(exp_resp));
    for (int i = 0; i < bready_delay; i++) begin
      tick();
      check({tag, ".bvalid_hold"}, 64'(BVALID), 64'd1);
      check({tag, ".bresp_hold"}, 64'(BRESP), 64'(exp_resp));
      check({tag, ".awready_resp"}, 64'(AWREADY), 64'd0);
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    model_bcnt++;
    check({tag, ".bvalid_done"}, 64'(BVALID), 64'd0);
    check({tag, ".awready_done"}, 64'(AWREADY), 64'd1);
    check({tag, ".burst_cnt"}, 64'(burst_cnt), 64'(model_bcnt[15:0]));
  endtask

  task automatic peek(input logic [7:0] idx, input logic [63:0] exp, input string tag);
    dbg_addr = idx;
    #1;
    check(tag, dbg_rdata, exp);
  endtask

  task automatic scan(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      dbg_addr = 8'(i);
      #1;
      check($sformatf("%s.mem[%0d]", tag, i), dbg_rdata, model_mem[i]);
    end
    tick();
  endtask

  initial begin
    ARstn = 1'b0; AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0; dbg_addr = '0;
    #1;
    check("rst.awready", 64'(AWREADY), 64'd1);
    check("rst.wready", 64'(WREADY), 64'd0);
    check("rst.bvalid", 64'(BVALID), 64'd0);
    check("rst.bid", 64'(BID), 64'd0);
    check("rst.bresp", 64'(BRESP), 64'd0);
    check("rst.burst_cnt", 64'(burst_cnt), 64'd0);
    repeat (2) @(posedge AClk);
    #1;
    ARstn = 1'b1;
    tick();

    // Single-beat reference write
    q_data = '{64'h1122334455667788}; q_strb = '{8'hFF};
    run_burst(8'h25, 32'h10, 8'd0, 3'd3, 2'b01, "single");
    check("single.bid_const", 64'(BID), 64'd5);
    peek(8'd2, 64'h1122334455667788, "single.mem2");
    check("single.cnt_const", 64'(burst_cnt), 64'd1);

    // Full-memory fill so every word is known to the model
    load(DEPTH, 1'b0);
    run_burst(8'h01, 32'h0, 8'd255, 3'd3, 2'b01, "fill");
    scan("fill");

    // Gapped INCR
    q_data = '{64'hA0, 64'hA1, 64'hA2, 64'hA3}; q_strb = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    gap_alt = 1'b1;
    run_burst(8'h02, 32'h0, 8'd3, 3'd3, 2'b01, "gapped");
    gap_alt = 1'b0;
    for (int i = 0; i < 4; i++) peek(8'(i), 64'hA0 + 64'(i), "gapped.mem");

    // Byte strobes
    q_data = '{64'hFFFFFFFFFFFFFFFF}; q_strb = '{8'hFF};
    run_burst(8'h03, 32'h28, 8'd0, 3'd3, 2'b01, "strb_set");
    q_data = '{64'h0}; q_strb = '{8'h0F};
    run_burst(8'h04, 32'h28, 8'd0, 3'd3, 2'b01, "strb_part");
    peek(8'd5, 64'hFFFFFFFF00000000, "strb.mem5");

    // FIXED with BREADY backpressure
    q_data = '{64'd1, 64'd2, 64'd3}; q_strb = '{8'hFF, 8'hFF, 8'hFF};
    bready_delay = 5;
    run_burst(8'h06, 32'h8, 8'd2, 3'd3, 2'b00, "fixed");
    bready_delay = 0;
    peek(8'd1, 64'd3, "fixed.mem1");

    // Error responses
    load(1, 1'b0);
    run_burst(8'h07, 32'h30, 8'd0, 3'd2, 2'b01, "err_size");
    check("err_size.bresp_const", 64'(BRESP), 64'd2);
    load(2, 1'b0);
    run_burst(8'h08, 32'h7F8, 8'd1, 3'd3, 2'b01, "err_end");
    load(2, 1'b0);
    force_last = 0;
    run_burst(8'h09, 32'h40, 8'd1, 3'd3, 2'b01, "err_early_last");
    load(3, 1'b0);
    force_last = 2;
    run_burst(8'h0A, 32'h50, 8'd2, 3'd3, 2'b01, "err_no_last");
    force_last = -1;
    load(4, 1'b0);
    run_burst(8'h0B, 32'h80, 8'd3, 3'd3, 2'b10, "err_wrap");
    load(2, 1'b1);
    simul = 1'b1;
    run_burst(8'h0C, 32'h90, 8'd1, 3'd3, 2'b01, "aw_w_same");
    simul = 1'b0;
    scan("directed");

    // Randomized bursts
    gap_rand = 1'b1;
    for (int n = 0; n < 25; n++) begin
      logic [7:0]  len;
      logic [1:0]  bt;
      logic [2:0]  sz;
      len = 8'($urandom_range(0, 15));
      bt  = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 3'd2 : 3'd3;
      force_last = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : -1;
      bready_delay = $urandom_range(0, 3);
      load(int'(len) + 1, 1'b1);
      run_burst(8'($urandom), 32'($urandom_range(0, 2111)), len, sz, bt, $sformatf("rnd%0d", n));
    end
    gap_rand = 1'b0; force_last = -1; bready_delay = 0;
    scan("random");

    // Reset in the middle of a burst
    load(4, 1'b0);
    AWID = 8'h3C; AWADDR = 32'h100; AWLEN = 8'd3; AWSIZE = 3'd3; AWBURST = 2'b01; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    WVALID = 1'b1; WDATA = q_data[0]; WSTRB = 8'hFF; WLAST = 1'b0;
    tick();
    WVALID = 1'b0;
    model_mem[32] = q_data[0];
    check("midrst.in_data", 64'(WREADY), 64'd1);
    ARstn = 1'b0;
    #1;
    check("midrst.awready", 64'(AWREADY), 64'd1);
    check("midrst.wready", 64'(WREADY), 64'd0);
    check("midrst.bvalid", 64'(BVALID), 64'd0);
    check("midrst.bid", 64'(BID), 64'd0);
    check("midrst.bresp", 64'(BRESP), 64'd0);
    check("midrst.burst_cnt", 64'(burst_cnt), 64'd0);
    tick();
    ARstn = 1'b1;
    tick();
    check("midrst.no_bvalid", 64'(BVALID), 64'd0);
    peek(8'd32, model_mem[32], "midrst.kept");
    model_bcnt = 0;
    load(1, 1'b0);
    run_burst(8'h11, 32'h108, 8'd0, 3'd3, 2'b01, "after_rst");
    check("after_rst.okay", 64'(BRESP), 64'd0);
    scan("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
